// File: rtl/if_stage_if.sv
// +----------------------------------------------------------------------------+
// | Module   : if_stage_if                                                     |
// | Purpose  : Fetch-stage bus bundle: stall/redirect in, IF/ID and SRAM out.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

interface if_stage_if;
    logic [`StallBus]          stall;
    logic [`BR_WD-1:0]         br_bus;
    logic [`IF_TO_ID_WD-1:0]   if_to_id_bus;
    logic                      inst_sram_en;
    logic [3:0]                inst_sram_wen;
    logic [31:0]               inst_sram_addr;
    logic [31:0]               inst_sram_wdata;
    logic                      fetch_err;

    // The fetch stage is the master: it owns the fetch request and IF/ID payload.
    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output fetch_err
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  fetch_err
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : if_stage                                                        |
// | Purpose  : Instruction fetch PC sequencer with stall-safe branch redirect. |
// |            Optional macro IF_MISALIGN_GUARD_EN rejects misaligned targets. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_stage (
    input  wire          clk,
    input  wire          rst,
    if_stage_if.master   bus_io
);

    localparam logic [31:0] C_RESET_PC = 32'hBFBF_FFFC;
    localparam logic [31:0] C_BOOT_PC  = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         ce_q, ce_d;
    logic [31:0]  pend_q, pend_d;
    logic         fetch_err_q, fetch_err_d;

    logic         w_br_e_raw;
    logic [31:0]  w_br_addr;
    logic         w_br_e;
    logic         w_stop;
    logic [31:0]  w_next_pc;
    logic         w_unused_stall;

    assign w_br_e_raw     = bus_io.br_bus[32];
    assign w_br_addr      = bus_io.br_bus[31:0];
    assign w_stop         = (bus_io.stall[0] == `Stop);
    assign w_unused_stall = ^bus_io.stall[5:1];

`ifdef IF_MISALIGN_GUARD_EN
    logic w_misaligned;

    // A misaligned redirect is dropped as if no request arrived; the error sticks.
    assign w_misaligned = w_br_e_raw && (w_br_addr[1:0] != 2'b00);
    assign w_br_e       = w_br_e_raw && !w_misaligned;
    assign fetch_err_d  = fetch_err_q | w_misaligned;
`else
    assign w_br_e       = w_br_e_raw;
    assign fetch_err_d  = 1'b0;
`endif

    assign w_next_pc = (state_q == ST_PEND) ? pend_q :
                       w_br_e               ? w_br_addr :
                                              pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        pend_d  = pend_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                ce_d    = 1'b1;
                pc_d    = C_BOOT_PC;
            end
            ST_RUN: begin
                if (!w_stop) begin
                    pc_d = w_next_pc;
                end else if (w_br_e) begin
                    // Park the redirect until the PC stage is released.
                    pend_d  = w_br_addr;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_stop) begin
                    if (w_br_e) begin
                        pend_d = w_br_addr;
                    end
                end else begin
                    pc_d    = w_next_pc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                ce_d    = 1'b0;
                pc_d    = C_RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= C_RESET_PC;
            ce_q        <= 1'b0;
            pend_q      <= 32'h0000_0000;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_q      <= pend_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus_io.if_to_id_bus    = {ce_q, pc_q};
    assign bus_io.inst_sram_en    = ce_q;
    assign bus_io.inst_sram_addr  = pc_q;
    assign bus_io.inst_sram_wen   = 4'b0000;
    assign bus_io.inst_sram_wdata = 32'h0000_0000;
    assign bus_io.fetch_err       = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_if_stage                                                     |
// | Purpose  : Directed scoreboard bench for if_stage (both macro builds).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_stage;

    logic clk;
    logic rst;
    if_stage_if bus ();

    if_stage dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef IF_MISALIGN_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // Drive one cycle, queue what the fetch outputs must show after the edge, then check.
    task automatic step(input logic r, input logic st0, input logic be,
                        input logic [31:0] ba, input logic e_en,
                        input logic [31:0] e_addr, input logic e_err,
                        input string tag);
        exp_t e;
        exp_t o;
        rst        = r;
        bus.stall  = {5'b0, st0};
        bus.br_bus = {be, ba};
        e.en = e_en; e.addr = e_addr; e.err = e_err; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        n_checks++;
        assert (bus.inst_sram_en === o.en) else begin
            n_errors++;
            $error("FAIL %s en: observed %b expected %b", o.tag, bus.inst_sram_en, o.en);
        end
        n_checks++;
        assert (bus.inst_sram_addr === o.addr) else begin
            n_errors++;
            $error("FAIL %s addr: observed %h expected %h", o.tag, bus.inst_sram_addr, o.addr);
        end
        n_checks++;
        assert (bus.if_to_id_bus === {o.en, o.addr}) else begin
            n_errors++;
            $error("FAIL %s if_to_id: observed %h expected %h", o.tag, bus.if_to_id_bus, {o.en, o.addr});
        end
        n_checks++;
        assert (bus.fetch_err === o.err) else begin
            n_errors++;
            $error("FAIL %s fetch_err: observed %b expected %b", o.tag, bus.fetch_err, o.err);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.stall  = '0;
        bus.br_bus = '0;

        // Reset held for three cycles.
        step(1, 0, 0, 32'h0,           0, 32'hBFBF_FFFC, 0, "rst0");
        step(1, 0, 1, 32'h1234_5678,   0, 32'hBFBF_FFFC, 0, "rst1");
        step(1, 1, 0, 32'h0,           0, 32'hBFBF_FFFC, 0, "rst2");

        // Boot sequence.
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0000, 0, "boot0");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0004, 0, "seq4");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0008, 0, "seq8");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_000C, 0, "seqC");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0010, 0, "seq10");

        // Unstalled redirect takes effect next cycle.
        step(0, 0, 1, 32'hBFC0_0100,   1, 32'hBFC0_0100, 0, "br100");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0104, 0, "br104");
        step(0, 0, 1, 32'hBFC0_0020,   1, 32'hBFC0_0020, 0, "br20");

        // Redirect arriving under stall is parked then applied.
        step(0, 1, 1, 32'hBFC0_0200,   1, 32'hBFC0_0020, 0, "stl1");
        step(0, 1, 0, 32'h0,           1, 32'hBFC0_0020, 0, "stl2");
        step(0, 1, 0, 32'h0,           1, 32'hBFC0_0020, 0, "stl3");
        step(0, 0, 1, 32'hBFC0_0BAD,   1, 32'hBFC0_0200, 0, "rel200");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0204, 0, "seq204");

        // Back-to-back redirects.
        step(0, 0, 1, 32'hBFC0_0500,   1, 32'hBFC0_0500, 0, "b2b500");
        step(0, 0, 1, 32'hBFC0_0600,   1, 32'hBFC0_0600, 0, "b2b600");

        // Plain stall holds the PC.
        step(0, 1, 0, 32'h0,           1, 32'hBFC0_0600, 0, "hold");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0604, 0, "seq604");

        // Newest parked request wins.
        step(0, 1, 1, 32'hBFC0_0280,   1, 32'hBFC0_0604, 0, "pnd1");
        step(0, 1, 1, 32'hBFC0_0300,   1, 32'hBFC0_0604, 0, "pnd2");
        step(0, 1, 0, 32'h0,           1, 32'hBFC0_0604, 0, "pnd3");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0300, 0, "rel300");

        // Reset in the middle of a pending redirect.
        step(0, 1, 1, 32'hBFC0_0400,   1, 32'hBFC0_0300, 0, "pnd400");
        step(1, 1, 1, 32'hBFC0_0700,   0, 32'hBFBF_FFFC, 0, "rstpnd");
        step(0, 1, 1, 32'hBFC0_0800,   1, 32'hBFC0_0000, 0, "reboot");
        step(0, 0, 0, 32'h0,           1, 32'hBFC0_0004, 0, "nopend");

        // Address wrap.
        step(0, 0, 1, 32'hFFFF_FFFC,   1, 32'hFFFF_FFFC, 0, "top");
        step(0, 0, 0, 32'h0,           1, 32'h0000_0000, 0, "wrap");

        // Misaligned redirect target.
        step(0, 0, 1, 32'hBFC0_0040,   1, 32'hBFC0_0040, 0, "br40");
        if (GUARD) begin
            step(0, 0, 1, 32'hBFC0_0402, 1, 32'hBFC0_0044, 1, "mis");
            step(0, 0, 0, 32'h0,         1, 32'hBFC0_0048, 1, "missticky");
            step(0, 1, 1, 32'hBFC0_0501, 1, 32'hBFC0_0048, 1, "misstall");
            step(0, 0, 0, 32'h0,         1, 32'hBFC0_004C, 1, "misnopend");
        end else begin
            step(0, 0, 1, 32'hBFC0_0402, 1, 32'hBFC0_0402, 0, "mis");
            step(0, 0, 0, 32'h0,         1, 32'hBFC0_0406, 0, "misseq");
        end
        step(1, 0, 0, 32'h0,           0, 32'hBFBF_FFFC, 0, "errclr");

        n_checks++;
        assert (bus.inst_sram_wen === 4'b0000 && bus.inst_sram_wdata === 32'h0) else begin
            n_errors++;
            $error("FAIL wen_wdata: observed %b/%h expected 0000/0", bus.inst_sram_wen, bus.inst_sram_wdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: IF

Interface
REQ-001 SHALL have parameter-free ports; widths come from lib/defines.vh (`StallBus, `BR_WD=33, `IF_TO_ID_WD=33).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 stall  input  `StallBus  pipeline stall vector; bit 0 = PC stage, bit 1 = IF/ID register; `Stop=1, `NoStop=0.
REQ-005 br_bus  input  `BR_WD  {br_e[32], br_addr[31:0]} redirect request from decode.
REQ-006 if_to_id_bus  output  `IF_TO_ID_WD  {ce[32], pc[31:0]} of the instruction being fetched this cycle.
REQ-007 inst_sram_en  output  1  fetch enable, equal to ce.
REQ-008 inst_sram_wen  output  4  constant 4'b0000.
REQ-009 inst_sram_addr  output  32  fetch address, equal to pc.
REQ-010 inst_sram_wdata  output  32  constant 32'b0.
REQ-011 fetch_err  output  1  sticky flag: a misaligned redirect was rejected (see Configuration).

Function
REQ-012 SHALL hold pc_reg (32b), ce_reg (1b), pend_addr (32b), 2-bit state: BOOT, RUN, PEND.
REQ-013 next_pc SHALL be pend_addr in PEND, else br_addr when br_e=1, else pc_reg+4 (32b modulo, 0xFFFF_FFFC+4 wraps to 0x0000_0000).
REQ-014 BOOT: ce_reg=0; next cycle without rst -> RUN, ce_reg<=1, pc_reg<=0xBFC0_0000 regardless of stall and br_e.
REQ-015 RUN, stall[0]=NoStop: pc_reg<=next_pc; remain RUN.
REQ-016 RUN, stall[0]=Stop, br_e=0: pc_reg, ce_reg held; remain RUN.
REQ-017 RUN, stall[0]=Stop, br_e=1: pc_reg held; pend_addr<=br_addr; -> PEND.
REQ-018 PEND, stall[0]=Stop: pc_reg held; if br_e=1, pend_addr<=br_addr (newest request wins); remain PEND.
REQ-019 PEND, stall[0]=NoStop: pc_reg<=pend_addr (br_e that cycle ignored); -> RUN.
REQ-020 Redirect latency: br_e sampled at cycle N with no stall -> inst_sram_addr=br_addr in cycle N+1.
REQ-021 inst_sram_en, inst_sram_addr, if_to_id_bus SHALL be combinational from ce_reg/pc_reg only; no path from br_bus or stall to outputs.
REQ-022 Two consecutive br_e pulses without stall SHALL each take effect in their following cycle; no request lost.

Reset
REQ-023 rst=1 at any posedge SHALL force state=BOOT, ce_reg=0, pc_reg=0xBFBF_FFFC, pend_addr=0, fetch_err=0, overriding stall and br_bus, including mid-PEND.
REQ-024 During and immediately after reset: inst_sram_en=0, if_to_id_bus=={1'b0, 32'hBFBF_FFFC}.

Configuration
REQ-025 Macro IF_MISALIGN_GUARD_EN SHALL gate an alignment check on redirect targets.
REQ-026 Defined: br_e with br_addr[1:0]!=0 SHALL be discarded (treated as br_e=0 in REQ-013..019) and fetch_err<=1 until reset.
REQ-027 Undefined: br_addr used unchanged, fetch_err tied to 0, no check logic synthesized.

Verification
REQ-028 rst high 3 cycles then low, no stall -> sram_en 0 during reset; addr sequence 0xBFC0_0000, 0xBFC0_0004, 0xBFC0_0008 with en=1.
REQ-029 At pc=0xBFC0_0010, br_e=1, br_addr=0xBFC0_0100 one cycle, no stall -> next addr 0xBFC0_0100, then 0xBFC0_0104.
REQ-030 At pc=0xBFC0_0020, stall[0]=1 for 3 cycles, br_e=1 addr 0xBFC0_0200 in first stall cycle only -> addr holds 0xBFC0_0020 for 3 cycles, then 0xBFC0_0200.
REQ-031 In PEND, second br_e addr 0xBFC0_0300 while still stalled -> after release addr=0xBFC0_0300, not first target.
REQ-032 rst pulsed while in PEND -> BOOT, pend discarded, post-reset addr 0xBFC0_0000.
REQ-033 With IF_MISALIGN_GUARD_EN, br_e addr 0xBFC0_0402 at pc=0xBFC0_0040 -> next addr 0xBFC0_0044, fetch_err=1 held; without macro -> next addr 0xBFC0_0402, fetch_err=0.
